// File: rtl/simon_pkg.sv
// Shared types and default timing for the Simon sequencer and autoplayer.
// Button encoding, replay FSM states and round/press timing defaults.
package simon_pkg;

  localparam int SIMON_DEPTH      = 32;
  localparam int SIMON_HOLD_TICKS = 30;
  localparam int SIMON_GAP_TICKS  = 30;

  typedef logic [1:0] button_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_PRESS,
    S_DONE
  } state_t;

endpackage

// File: rtl/simon_seq_mem.sv
// Round buffer: records Simon's presses with a saturating write index
// and a sticky overflow flag for rounds longer than the buffer.
module simon_seq_mem
  import simon_pkg::*;
#(
  parameter int DEPTH  = SIMON_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  button_t           wdata,
  input  logic [ADDR_W-1:0] raddr,
  output button_t           rdata,
  output logic [ADDR_W:0]   wr_idx,
  output logic              overflow
);

  button_t           mem [DEPTH];
  logic              full;
  logic              wr_en;
  logic [ADDR_W-1:0] waddr;

  assign full  = wr_idx == (ADDR_W+1)'(DEPTH);
  // A new round restarts at slot 0 even if a press lands on the same cycle.
  assign wr_en = we && (clr || !full);
  assign waddr = clr ? '0 : wr_idx[ADDR_W-1:0];
  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx   <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_idx <= we ? (ADDR_W+1)'(1) : '0;
    end else if (we) begin
      if (full) overflow <= 1'b1;
      else      wr_idx   <= wr_idx + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: rtl/simon_autoplayer.sv
// Player-side autoplayer: records Simon's round, then replays it on the
// player button interface with fixed gap/hold timing.
module simon_autoplayer
  import simon_pkg::*;
#(
  parameter int DEPTH      = SIMON_DEPTH,
  parameter int ADDR_W     = 5,
  parameter int HOLD_TICKS = SIMON_HOLD_TICKS,
  parameter int GAP_TICKS  = SIMON_GAP_TICKS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            simon_turn,
  input  logic [1:0]      simon_num,
  input  logic            simon_pressed,
  input  logic            game_over,
  output logic [1:0]      player_num,
  output logic            player_pressed,
  output logic [ADDR_W:0] seq_len,
  output logic            overflow,
  output logic            busy
);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  button_t           num_d, rd_data;
  logic              pressed_d, busy_d;
  logic              turn_q, pressed_q, fall_q;
  logic              turn_rise, turn_fall, press_rise;
  logic              abort;
  logic [ADDR_W:0]   wr_idx;

  assign turn_rise  = simon_turn & ~turn_q;
  assign turn_fall  = ~simon_turn & turn_q;
  assign press_rise = simon_pressed & ~pressed_q;

  simon_seq_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .clr     (turn_rise),
    .we      (press_rise & simon_turn),
    .wdata   (simon_num),
    .raddr   (rd_q),
    .rdata   (rd_data),
    .wr_idx  (wr_idx),
    .overflow(overflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      turn_q    <= 1'b0;
      pressed_q <= 1'b0;
      fall_q    <= 1'b0;
      seq_len   <= '0;
    end else begin
      turn_q    <= simon_turn;
      pressed_q <= simon_pressed;
      fall_q    <= turn_fall;
      if (turn_fall) seq_len <= wr_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rd_q           <= '0;
      player_num     <= '0;
      player_pressed <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_q           <= rd_d;
      player_num     <= num_d;
      player_pressed <= pressed_d;
      busy           <= busy_d;
    end
  end

  assign abort = (state_q != S_IDLE) &&
                 (turn_rise || game_over || !enable);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    num_d   = player_num;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fall_q && enable && !game_over) begin
            rd_d    = '0;
            cnt_d   = '0;
            state_d = (seq_len != '0) ? S_GAP : S_DONE;
          end
        end
        S_GAP: begin
          if (cnt_q == 8'(GAP_TICKS - 1)) begin
            cnt_d   = '0;
            num_d   = rd_data;
            state_d = S_PRESS;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_PRESS: begin
          if (cnt_q == 8'(HOLD_TICKS - 1)) begin
            cnt_d   = '0;
            rd_d    = rd_q + ADDR_W'(1);
            state_d = ({1'b0, rd_q} + (ADDR_W+1)'(1) == seq_len)
                      ? S_DONE : S_GAP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          if (turn_rise) state_d = S_IDLE;
        end
      endcase
    end
    if (state_d == S_IDLE || state_d == S_DONE) num_d = '0;
    pressed_d = state_d == S_PRESS;
    busy_d    = state_d == S_GAP || state_d == S_PRESS;
  end

endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench for simon_autoplayer: timed replay table plus
// hand-written rounds for abort, game over, overflow and reset.
module tb_simon_autoplayer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       simon_turn = 1'b0;
  logic [1:0] simon_num = 2'd0;
  logic       simon_pressed = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] player_num;
  logic       player_pressed;
  logic [5:0] seq_len;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int passes = 0;
  logic [1:0] exp_buf [64];

  typedef struct {
    int         n;
    logic       pr;
    logic       bz;
    logic [1:0] num;
  } vec_t;
  vec_t tbl [14];

  always #5 clk = ~clk;

  simon_autoplayer dut (
    .clk           (clk),
    .reset         (rst_n),
    .enable        (enable),
    .simon_turn    (simon_turn),
    .simon_num     (simon_num),
    .simon_pressed (simon_pressed),
    .game_over     (game_over),
    .player_num    (player_num),
    .player_pressed(player_pressed),
    .seq_len       (seq_len),
    .overflow      (overflow),
    .busy          (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic press(input logic [1:0] b);
    @(negedge clk);
    simon_num = b;
    simon_pressed = 1'b1;
    @(negedge clk);
    simon_pressed = 1'b0;
  endtask

  task automatic start_round();
    @(negedge clk);
    simon_turn = 1'b1;
  endtask

  task automatic end_round();
    @(negedge clk);
    simon_turn = 1'b0;
  endtask

  task automatic expect_replay(input int n);
    int   idx;
    logic prev;
    logic seen;
    idx = 0;
    prev = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < n * 60 + 60; c++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      if (player_pressed && !prev) begin
        if (idx < n)
          chk($sformatf("replay_num[%0d]", idx), player_num, exp_buf[idx]);
        idx++;
      end
      prev = player_pressed;
    end
    chk("replay_count", idx, n);
    chk("replay_seq_len", seq_len, n);
    chk("replay_busy_seen", seen, n > 0);
    chk("replay_busy_end", busy, 0);
  endtask

  initial begin
    int   cur;
    int   rises;
    logic prev;
    logic seen;

    // n = cycles after the clock edge that registers the turn fall
    tbl[0]  = '{0,   1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1,   1'b0, 1'b1, 2'd0};
    tbl[2]  = '{30,  1'b0, 1'b1, 2'd0};
    tbl[3]  = '{31,  1'b1, 1'b1, 2'd2};
    tbl[4]  = '{60,  1'b1, 1'b1, 2'd2};
    tbl[5]  = '{61,  1'b0, 1'b1, 2'd0};
    tbl[6]  = '{90,  1'b0, 1'b1, 2'd0};
    tbl[7]  = '{91,  1'b1, 1'b1, 2'd0};
    tbl[8]  = '{120, 1'b1, 1'b1, 2'd0};
    tbl[9]  = '{121, 1'b0, 1'b1, 2'd0};
    tbl[10] = '{151, 1'b1, 1'b1, 2'd3};
    tbl[11] = '{180, 1'b1, 1'b1, 2'd3};
    tbl[12] = '{181, 1'b0, 1'b0, 2'd0};
    tbl[13] = '{200, 1'b0, 1'b0, 2'd0};

    repeat (2) @(negedge clk);
    chk("rst_pressed", player_pressed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_len", seq_len, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_num", player_num, 0);
    rst_n = 1'b1;
    enable = 1'b1;

    start_round();
    press(2'd2);
    press(2'd0);
    press(2'd3);
    end_round();
    cur = -1;
    for (int i = 0; i < 14; i++) begin
      while (cur < tbl[i].n) begin
        @(negedge clk);
        cur++;
      end
      chk($sformatf("tbl_pressed@%0d", tbl[i].n), player_pressed, tbl[i].pr);
      chk($sformatf("tbl_busy@%0d", tbl[i].n), busy, tbl[i].bz);
      if (tbl[i].pr)
        chk($sformatf("tbl_num@%0d", tbl[i].n), player_num, tbl[i].num);
    end
    chk("tbl_seq_len", seq_len, 3);

    start_round();
    repeat (3) @(negedge clk);
    end_round();
    expect_replay(0);

    @(negedge clk);
    simon_turn = 1'b1;
    simon_pressed = 1'b1;
    simon_num = 2'd2;
    @(negedge clk);
    simon_pressed = 1'b0;
    press(2'd1);
    end_round();
    exp_buf[0] = 2'd2;
    exp_buf[1] = 2'd1;
    expect_replay(2);

    start_round();
    press(2'd1);
    press(2'd2);
    press(2'd3);
    end_round();
    rises = 0;
    prev = 1'b0;
    for (int c = 0; c < 300 && rises < 2; c++) begin
      @(negedge clk);
      if (player_pressed && !prev) rises++;
      prev = player_pressed;
    end
    chk("abort_reached_press2", rises, 2);
    repeat (4) @(negedge clk);
    simon_turn = 1'b1;
    @(negedge clk);
    chk("abort_pressed", player_pressed, 0);
    chk("abort_busy", busy, 0);
    press(2'd3);
    press(2'd1);
    end_round();
    exp_buf[0] = 2'd3;
    exp_buf[1] = 2'd1;
    expect_replay(2);

    start_round();
    press(2'd0);
    press(2'd1);
    end_round();
    repeat (5) @(negedge clk);
    chk("go_in_gap", busy, 1);
    game_over = 1'b1;
    @(negedge clk);
    chk("go_busy", busy, 0);
    chk("go_pressed", player_pressed, 0);
    start_round();
    press(2'd3);
    end_round();
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy || player_pressed) seen = 1'b1;
    end
    chk("go_blocked", seen, 0);
    chk("go_seq_len", seq_len, 1);
    game_over = 1'b0;

    start_round();
    for (int i = 0; i < 33; i++) begin
      if (i < 32) exp_buf[i] = 2'((i * 3 + 1) % 4);
      press(2'((i * 3 + 1) % 4));
      if (i == 31) chk("ovf_at_32", overflow, 0);
    end
    chk("ovf_at_33", overflow, 1);
    end_round();
    expect_replay(32);

    start_round();
    press(2'd2);
    end_round();
    for (int c = 0; c < 100 && !player_pressed; c++) @(negedge clk);
    chk("rstp_reached_press", player_pressed, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstp_pressed", player_pressed, 0);
    chk("rstp_busy", busy, 0);
    chk("rstp_seq_len", seq_len, 0);
    chk("rstp_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstp_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/simon_autoplayer.md
Name: simon_autoplayer

Overview:
- Player-side counterpart of the Simon sequencer.
- While Simon has the turn, it watches Simon's presses and records each round's displayed sequence into a small buffer.
- When the turn passes to the player, it replays the recorded sequence on the player button interface (player_num / player_pressed) with fixed press and gap timing.
- Used as a demo/attract-mode player and as a self-checking stimulus source for the game core.

Parameters:
- DEPTH, 32, maximum sequence length stored per round (power of two).
- ADDR_W, 5, log2(DEPTH).
- HOLD_TICKS, 30, clk cycles player_pressed is held high per replayed press (1..255).
- GAP_TICKS, 30, clk cycles of release before each replayed press (1..255).

Ports:
- clk  in  1  game clock (60 Hz tick domain).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = replay allowed; 0 = record only, player outputs held low.
- simon_turn  in  1  1 while Simon presents the sequence.
- simon_num  in  2  button Simon is showing.
- simon_pressed  in  1  Simon button-lit strobe.
- game_over  in  1  game has ended.
- player_num  out  2  button being replayed.
- player_pressed  out  1  replayed press level.
- seq_len  out  ADDR_W+1  length of last completed recorded round.
- overflow  out  1  sticky; a round exceeded DEPTH presses.
- busy  out  1  high while replay is in progress (GAP/PRESS states).

Behaviour:
- Reset (reset low, async): all outputs 0; FSM = IDLE; write index, read index, tick counter and edge registers = 0. Buffer contents are don't-care.
- Inputs are registered once (simon_turn_q, simon_pressed_q). Edges are detected against the registered copy, so all reactions occur one cycle after the input change.
- Recording:
  - Rising edge of simon_turn: write index := 0.
  - Each rising edge of simon_pressed while simon_turn = 1: mem[wr_idx] := simon_num, sampled on the same cycle as the edge; then wr_idx++.
  - If wr_idx = DEPTH when a press arrives: write dropped, overflow := 1 (sticky until reset).
  - Falling edge of simon_turn: seq_len := wr_idx (0..DEPTH) and replay starts.
- Replay FSM states:
  - IDLE: outputs low. On the simon_turn falling edge with enable = 1 and game_over = 0: rd_idx := 0, then go to GAP if seq_len > 0, otherwise go to DONE.
  - GAP: player_pressed = 0. Count GAP_TICKS cycles, then go to PRESS; player_num := mem[rd_idx].
  - PRESS: player_pressed = 1 for exactly HOLD_TICKS cycles. Then rd_idx++ and player_pressed := 0. If rd_idx+1 = seq_len go to DONE, otherwise go to GAP.
  - DONE: outputs low. Wait for the simon_turn rising edge, then go to IDLE.
- Outputs are registered. First player_pressed rise = falling edge detect + 1 + GAP_TICKS cycles.
- busy = 1 in GAP and PRESS.
- Abort conditions: simon_turn rising, game_over = 1, or enable = 0 in any non-IDLE state → IDLE next cycle, with player_pressed and busy forced to 0 in that same cycle. A press cut short by an abort is not counted.
- game_over = 1 also blocks new replays. Recording continues regardless of enable and game_over.
- Simultaneous simon_turn rising and simon_pressed rising: the index reset has priority and the press is written to mem[0] with wr_idx := 1.
- Arithmetic:
  - seq_len and wr_idx are ADDR_W+1 bits and saturate at DEPTH; they never wrap.
  - rd_idx is ADDR_W bits.
  - The tick counter is 8 bits, reset to 0 on every state entry.

Decomposition:
- Shared package simon_pkg:
  - 2-bit button_t type.
  - Replay FSM state enum (IDLE, GAP, PRESS, DONE).
  - Default DEPTH/HOLD_TICKS/GAP_TICKS constants, shared with the Simon sequencer.
- One sub-module, simon_seq_mem:
  - DEPTH x 2 register file.
  - Synchronous write, combinational read.
  - Holds the buffer plus wr_idx saturation and overflow logic.

Test Plan:
- Reset mid-PRESS (reset low for 1 cycle) → player_pressed, busy, seq_len and overflow read 0 immediately, asynchronously.
- Round of presses 2,0,3 (simon_turn high, three pulses), then simon_turn low, enable = 1, GAP = HOLD = 30 → seq_len = 3. Three player_pressed pulses of 30 cycles, separated by 30 low cycles, with player_num 2,0,3. The first rise is 31 cycles after the registered falling edge. Ends in DONE with busy = 0.
- simon_turn falls with zero presses → seq_len = 0, busy never asserts, no player_pressed.
- 33 presses in one round with DEPTH = 32 → overflow = 1, seq_len = 32, replay of 32 values that match the first 32 pressed.
- simon_turn rises during the second replayed PRESS → player_pressed low the next cycle, FSM IDLE, the new round records from index 0.
- game_over = 1 while in GAP → busy = 0 the next cycle. A subsequent simon_turn fall does not start a replay while game_over is high.
